flash_sample_reader: RTL and testbench

- Flash-side read engine that sits directly downstream of the audio address generator.
- Each start pulse from the generator fetches one 32-bit word from the flash Avalon-MM read port at the supplied word address.
- The word is split into two 16-bit audio samples, which are handed to the audio output path one per sample tick.
- Supports reverse playback by swapping sample order within the word.

---
 rtl/flash_sample_reader.sv | 128 ++++++++++++
 tb/tb_flash_sample_reader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/flash_sample_reader.sv
// Flash-side read engine: fetches one word per start pulse over Avalon-MM and
// plays it out as two half-width audio samples, optionally in reversed order.
module flash_sample_reader #(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK_50M,
    input  logic              reset,
    input  logic              start_fsm,
    input  logic [ADDR_W-1:0] in_address,
    input  logic              reverse,
    input  logic              sample_tick,
    input  logic              flash_mem_waitrequest,
    input  logic              flash_mem_readdatavalid,
    input  logic [DATA_W-1:0] flash_mem_readdata,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    output logic [DATA_W/2-1:0] audio_data,
    output logic              audio_valid,
    output logic              busy,
    output logic              rd_error
);
    // state        | meaning
    // S_IDLE       | waiting for start_fsm
    // S_REQ        | read asserted, held until waitrequest drops
    // S_WAIT_DATA  | request accepted, waiting for readdatavalid or timeout
    // S_OUT_FIRST  | present first sample of the word
    // S_WAIT_TICK  | waiting for the next sample_tick
    // S_OUT_SECOND | present second sample of the word
    localparam int HALF_W = DATA_W / 2;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_REQ        = 3'd1,
        S_WAIT_DATA  = 3'd2,
        S_OUT_FIRST  = 3'd3,
        S_WAIT_TICK  = 3'd4,
        S_OUT_SECOND = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_dir;
    logic [DATA_W-1:0]   r_word;
    logic [CNT_W-1:0]    r_cnt;
    logic [HALF_W-1:0]   r_audio;
    logic                r_valid;
    logic                r_err;
    logic                w_accept;
    logic                w_capture;
    logic                w_timeout;

    assign w_accept  = (r_state == S_REQ) && !flash_mem_waitrequest;
    assign w_capture = flash_mem_readdatavalid && (w_accept || (r_state == S_WAIT_DATA));
    // Down-counter loaded on acceptance; terminal count with no data is the abort.
    assign w_timeout = (r_state == S_WAIT_DATA) && !flash_mem_readdatavalid && (r_cnt == '0);

    always_ff @(posedge CLK_50M or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:       if (start_fsm) w_state_next = S_REQ;
            S_REQ:        if (w_accept) w_state_next = w_capture ? S_OUT_FIRST : S_WAIT_DATA;
            S_WAIT_DATA:  if (w_capture || w_timeout) w_state_next = S_OUT_FIRST;
            S_OUT_FIRST:  w_state_next = S_WAIT_TICK;
            S_WAIT_TICK:  if (sample_tick) w_state_next = S_OUT_SECOND;
            S_OUT_SECOND: w_state_next = S_IDLE;
            default:      w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50M or negedge reset) begin
        if (!reset) begin
            r_addr  <= '0;
            r_dir   <= 1'b0;
            r_word  <= '0;
            r_cnt   <= '0;
            r_audio <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if ((r_state == S_IDLE) && start_fsm) begin
                r_addr <= in_address;
                r_dir  <= reverse;
            end
            if (w_accept) begin
                r_cnt <= CNT_W'(TIMEOUT - 1);
            end else if (r_state == S_WAIT_DATA) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_capture) begin
                r_word <= flash_mem_readdata;
            end else if (w_timeout) begin
                r_word <= '0;
                r_err  <= 1'b1;
            end
            // Reverse playback emits the upper half first.
            if (r_state == S_OUT_FIRST) begin
                r_audio <= r_dir ? r_word[DATA_W-1:HALF_W] : r_word[HALF_W-1:0];
                r_valid <= 1'b1;
            end else if (r_state == S_OUT_SECOND) begin
                r_audio <= r_dir ? r_word[HALF_W-1:0] : r_word[DATA_W-1:HALF_W];
                r_valid <= 1'b1;
            end
        end
    end

    assign flash_mem_read       = (r_state == S_REQ);
    assign flash_mem_address    = r_addr;
    assign flash_mem_byteenable = 4'b1111;
    assign audio_data           = r_audio;
    assign audio_valid          = r_valid;
    assign busy                 = (r_state != S_IDLE);
    assign rd_error             = r_err;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Bench for flash_sample_reader: vector table of flash transactions with a
// sample scoreboard, plus a hand-written mid-transaction reset sequence.
module tb_flash_sample_reader;
    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;
    localparam int TO     = 8;
    localparam int NV     = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] in_addr;
    logic              rev;
    logic              tick;
    logic              waitreq;
    logic              rdv;
    logic [DATA_W-1:0] rdata;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [15:0]       adata;
    logic              avalid;
    logic              busy;
    logic              err;

    int         n_checks = 0;
    int         n_err    = 0;
    bit         exp_err  = 1'b0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [ADDR_W-1:0] addr;
        bit                rev;
        logic [DATA_W-1:0] data;
        int                wait_n;      // cycles of waitrequest=1
        int                dv;          // rdv delay after acceptance cycle, -1 = never
        bit                tick_early;  // pulse sample_tick during REQ
        bit                busy_start;  // second start while busy
        bit                drop_start;  // start during OUT_SECOND
        logic [15:0]       exp0;
        logic [15:0]       exp1;
    } vec_t;

    vec_t vecs[NV];

    flash_sample_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
        .CLK_50M                 (clk),
        .reset                   (rst_n),
        .start_fsm               (start),
        .in_address              (in_addr),
        .reverse                 (rev),
        .sample_tick             (tick),
        .flash_mem_waitrequest   (waitreq),
        .flash_mem_readdatavalid (rdv),
        .flash_mem_readdata      (rdata),
        .flash_mem_read          (rd),
        .flash_mem_address       (addr),
        .flash_mem_byteenable    (be),
        .audio_data              (adata),
        .audio_valid             (avalid),
        .busy                    (busy),
        .rd_error                (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every audio_valid pulse must match the next queued sample.
    always @(negedge clk) begin
        if (rst_n && avalid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", {16'h0, adata}, 32'h0);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("sample", {16'h0, adata}, {16'h0, e});
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int kend;
        kend = (v.dv < 0) ? v.wait_n + TO : v.wait_n + v.dv;
        exp_q.push_back(v.exp0);
        exp_q.push_back(v.exp1);
        @(posedge clk); #1;
        start = 1'b1; in_addr = v.addr; rev = v.rev;
        @(negedge clk);
        chk("idle_busy", {31'h0, busy}, 32'h0);
        for (int k = 0; k <= kend; k++) begin
            @(posedge clk); #1;
            start   = v.busy_start && (k == 1);
            in_addr = ~v.addr;
            rev     = ~v.rev;
            waitreq = (k < v.wait_n);
            rdv     = (v.dv >= 0) && (k == v.wait_n + v.dv);
            rdata   = rdv ? v.data : ~v.data;
            tick    = v.tick_early && (k == 0);
            @(negedge clk);
            chk("read", {31'h0, rd}, {31'h0, (k <= v.wait_n)});
            chk("address", {9'h0, addr}, {9'h0, v.addr});
            chk("busy", {31'h0, busy}, 32'h1);
            chk("rd_error", {31'h0, err}, {31'h0, exp_err});
            chk("early_valid", {31'h0, avalid}, 32'h0);
        end
        @(posedge clk); #1;
        start = 1'b0; rdv = 1'b0; waitreq = 1'b0; tick = 1'b0;
        if (v.dv < 0) exp_err = 1'b1;
        @(negedge clk);
        chk("first_pending", {31'h0, avalid}, 32'h0);
        chk("rd_error_set", {31'h0, err}, {31'h0, exp_err});
        @(posedge clk); #1;
        @(negedge clk);
        chk("first_valid", {31'h0, avalid}, 32'h1);
        chk("busy_tick", {31'h0, busy}, 32'h1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("tick_wait", {31'h0, avalid}, 32'h0);
            chk("read_after", {31'h0, rd}, 32'h0);
        end
        @(posedge clk); #1;
        tick = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        tick = 1'b0;
        start = v.drop_start;
        @(negedge clk);
        chk("second_pending", {31'h0, avalid}, 32'h0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("second_valid", {31'h0, avalid}, 32'h1);
        chk("busy_done", {31'h0, busy}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_after", {31'h0, busy}, 32'h0);
        chk("idle_read", {31'h0, rd}, 32'h0);
        chk("addr_kept", {9'h0, addr}, {9'h0, v.addr});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        vecs[0] = '{23'h00010,  1'b0, 32'hBEEF_1234, 0, 2, 1'b0, 1'b0, 1'b0, 16'h1234, 16'hBEEF};
        vecs[1] = '{23'h00010,  1'b1, 32'hAAAA_5555, 0, 2, 1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h5555};
        vecs[2] = '{23'h0ABCD,  1'b0, 32'hCAFE_0001, 5, 1, 1'b0, 1'b0, 1'b0, 16'h0001, 16'hCAFE};
        vecs[3] = '{23'h00000,  1'b1, 32'h1234_5678, 0, 0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h5678};
        vecs[4] = '{23'h7FFFF,  1'b0, 32'h0F0F_F0F0, 1, 3, 1'b1, 1'b1, 1'b1, 16'hF0F0, 16'h0F0F};
        vecs[5] = '{23'h7FFFFF, 1'b1, 32'h8001_7FFE, 0, 1, 1'b0, 1'b1, 1'b1, 16'h8001, 16'h7FFE};
        vecs[6] = '{23'h02222,  1'b0, 32'hDEAD_BEEF, 2, -1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[7] = '{23'h03333,  1'b0, 32'h5A5A_A5A5, 0, 1, 1'b0, 1'b0, 1'b0, 16'hA5A5, 16'h5A5A};

        rst_n = 1'b0; start = 1'b0; in_addr = '0; rev = 1'b0; tick = 1'b0;
        waitreq = 1'b0; rdv = 1'b0; rdata = '0;
        #2;
        chk("rst_read", {31'h0, rd}, 32'h0);
        chk("rst_addr", {9'h0, addr}, 32'h0);
        chk("rst_audio", {16'h0, adata}, 32'h0);
        chk("rst_valid", {31'h0, avalid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_be", {28'h0, be}, 32'hF);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // Reset during WAIT_DATA, then late data after release.
        @(posedge clk); #1;
        start = 1'b1; in_addr = 23'h01234; rev = 1'b0; waitreq = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; in_addr = '0;
        @(negedge clk);
        chk("mr_read", {31'h0, rd}, 32'h1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mr_err_sticky", {31'h0, err}, 32'h1);
        chk("mr_busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mr_read0", {31'h0, rd}, 32'h0);
        chk("mr_addr0", {9'h0, addr}, 32'h0);
        chk("mr_audio0", {16'h0, adata}, 32'h0);
        chk("mr_valid0", {31'h0, avalid}, 32'h0);
        chk("mr_busy0", {31'h0, busy}, 32'h0);
        chk("mr_err0", {31'h0, err}, 32'h0);
        chk("mr_be", {28'h0, be}, 32'hF);
        exp_err = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rdv = 1'b1; rdata = 32'h1111_2222;
        @(posedge clk); #1;
        rdv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("late_valid", {31'h0, avalid}, 32'h0);
            chk("late_busy", {31'h0, busy}, 32'h0);
            chk("late_audio", {16'h0, adata}, 32'h0);
            chk("late_read", {31'h0, rd}, 32'h0);
        end
        chk("sb_empty", exp_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
